// File: rtl/requests_pc_writer_if.sv
// ----------------------------------------------------------------------------
// requests_pc_writer_if
//   Byte stream from the PC link into the request writer.
//   rx_data  : byte offered by the link
//   rx_valid : rx_data is valid this cycle
//   rx_ready : writer accepts a byte this cycle (valid & ready = accepted)
//   master   : link side (drives data/valid)
//   slave    : writer side (drives ready)
// ----------------------------------------------------------------------------
interface requests_pc_writer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/requests_pc_writer.sv
// ----------------------------------------------------------------------------
// requests_pc_writer
//   Collects three-byte frames {address, data LSB, data MSB} from the PC link
//   and, when the address matches RQST_ADDR, presents the 16-bit request word
//   to the handler for exactly one cycle. Mismatched addresses and frames that
//   stall for TIMEOUT idle cycles are reported with one-cycle pulses.
//
//   clk              : clock, rising edge
//   rst              : synchronous reset, active low
//   rx               : byte stream (slave side of requests_pc_writer_if)
//   request_reg_data : request word, valid only during the WRITE cycle
//                      (bit0 start, bit1 reset, bit2 stop, bit3 conf)
//   addr_miss_o      : pulse, completed frame carried a foreign address
//   frame_err_o      : pulse, partial frame dropped after a stall
// ----------------------------------------------------------------------------
module requests_pc_writer #(
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] RQST_ADDR  = 8'h00,
    parameter int         TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    requests_pc_writer_if.slave       rx,
    output logic [DATA_WIDTH-1:0]     request_reg_data,
    output logic                      addr_miss_o,
    output logic                      frame_err_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GET_LSB, GET_MSB, WRITE} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [7:0]            r_addr;
    logic [7:0]            r_lsb;
    logic [DATA_WIDTH-1:0] r_req;
    logic                  r_miss;
    logic                  r_ferr;

    logic w_accept;
    logic w_expire;

    // Ready is a pure function of state; WRITE is the only bubble.
    assign rx.rx_ready = (r_state != WRITE);
    assign w_accept    = rx.rx_valid && (r_state != WRITE);
    assign w_expire    = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign request_reg_data = r_req;
    assign addr_miss_o      = r_miss;
    assign frame_err_o      = r_ferr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_lsb   <= '0;
            r_req   <= '0;
            r_miss  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            // All outputs are single-cycle pulses; they fall back to 0 unless
            // set again below.
            r_req  <= '0;
            r_miss <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_addr  <= rx.rx_data;
                        r_state <= GET_LSB;
                    end
                end
                GET_LSB: begin
                    if (w_accept) begin
                        r_lsb   <= rx.rx_data;
                        r_cnt   <= '0;
                        r_state <= GET_MSB;
                    end else if (w_expire) begin
                        r_cnt   <= '0;
                        r_ferr  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                GET_MSB: begin
                    if (w_accept) begin
                        // The MSB lands directly in the request register;
                        // a mismatched frame still takes the WRITE cycle so
                        // every frame has identical timing.
                        r_cnt   <= '0;
                        r_state <= WRITE;
                        if (r_addr == RQST_ADDR)
                            r_req <= DATA_WIDTH'({rx.rx_data, r_lsb});
                        else
                            r_miss <= 1'b1;
                    end else if (w_expire) begin
                        r_cnt   <= '0;
                        r_ferr  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_requests_pc_writer.sv
// ----------------------------------------------------------------------------
// tb_requests_pc_writer
//   Directed table of frames with constant expectations, a hand-written
//   reset-during-WRITE sequence, then randomized traffic against a frame-level
//   reference model. Outputs are sampled mid-cycle, before the next edge.
// ----------------------------------------------------------------------------
module tb_requests_pc_writer;
    localparam int         TO   = 4;
    localparam logic [7:0] ADDR = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        miss;
    logic        ferr;

    always #5 clk = ~clk;

    requests_pc_writer_if bus();

    requests_pc_writer #(
        .DATA_WIDTH(16),
        .RQST_ADDR (ADDR),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx              (bus.slave),
        .request_reg_data(req),
        .addr_miss_o     (miss),
        .frame_err_o     (ferr)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: bytes of the frame collected so far, idle run length,
    // and whether the current cycle is the post-frame bubble.
    logic [7:0]  m_bytes[$];
    int          m_idle  = 0;
    bit          m_write = 1'b0;
    logic [15:0] m_req   = '0;
    bit          m_miss  = 1'b0;
    bit          m_ferr  = 1'b0;

    typedef struct {
        bit          rn;
        bit          v;
        logic [7:0]  d;
        logic [18:0] exp;   // {rx_ready, request_reg_data, addr_miss_o, frame_err_o}
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit rn, bit v, logic [7:0] d,
                                bit rdy, logic [15:0] rq, bit ms, bit fe);
        vec_t x;
        x.rn  = rn;
        x.v   = v;
        x.d   = d;
        x.exp = {rdy, rq, ms, fe};
        tbl.push_back(x);
    endfunction

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got ready=%0b req=%h miss=%0b ferr=%0b, want ready=%0b req=%h miss=%0b ferr=%0b",
                      name, act[18], act[17:2], act[1], act[0], exp[18], exp[17:2], exp[1], exp[0]);
    endtask

    // Advance the model by one clock given this cycle's inputs.
    function automatic void model_step(bit rn, bit v, logic [7:0] d);
        m_req  = '0;
        m_miss = 1'b0;
        m_ferr = 1'b0;
        if (!rn) begin
            m_bytes.delete();
            m_idle  = 0;
            m_write = 1'b0;
        end else if (m_write) begin
            m_write = 1'b0;                 // byte (if any) is left on the link
        end else if (v) begin
            m_idle = 0;
            if (m_bytes.size() < 2) m_bytes.push_back(d);
            else begin
                m_write = 1'b1;
                if (m_bytes[0] == ADDR) m_req = {d, m_bytes[1]};
                else                    m_miss = 1'b1;
                m_bytes.delete();
            end
        end else if (m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin         // TIMEOUT idle cycles in a row
                m_bytes.delete();
                m_idle = 0;
                m_ferr = 1'b1;
            end
        end
    endfunction

    // Drive one cycle: apply inputs, sample DUT and model mid-cycle, clock.
    task automatic cycle(input bit rn, input bit v, input logic [7:0] d,
                         output logic [18:0] act, output logic [18:0] mexp);
        rst          = rn;
        bus.rx_valid = v;
        bus.rx_data  = d;
        #3;
        act  = {bus.rx_ready, req, miss, ferr};
        mexp = {~m_write, m_req, m_miss, m_ferr};
        model_step(rn, v, d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [18:0] act;
        logic [18:0] mexp;
        int          pv;

        // 00,01,00 -> 0001 in the WRITE cycle, ready low there
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h01, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 0,16'h0001,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        // back-to-back with valid held; the WRITE-cycle byte is held and reused
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h04, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h00, 0,16'h0004,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h01, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 0,16'h0001,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        // foreign address 05
        add(1,1,8'h05, 1,16'h0000,0,0);
        add(1,1,8'h08, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 0,16'h0000,1,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        // matching frame with zero data word
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 0,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        // LSB arrives on the 4th idle cycle: byte wins over the timeout
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h03, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 0,16'h0003,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        // 4 idle cycles after the address -> frame_err, then new frame whose
        // address is accepted in the error cycle itself
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,1);
        add(1,1,8'h02, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 0,16'h0002,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        // reset after the LSB; the MSB that follows starts a new frame
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h01, 1,16'h0000,0,0);
        add(0,0,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h05, 1,16'h0000,0,0);
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 0,16'h0005,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        // reset on the MSB edge: no pulse at all
        add(1,1,8'h00, 1,16'h0000,0,0);
        add(1,1,8'h09, 1,16'h0000,0,0);
        add(0,1,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);
        add(1,0,8'h00, 1,16'h0000,0,0);

        // Reset
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(posedge clk);
        #1;
        cycle(0, 0, 8'h00, act, mexp);
        check("reset_state", act, 19'b1_0000000000000000_0_0);

        // Directed table
        foreach (tbl[i]) begin
            cycle(tbl[i].rn, tbl[i].v, tbl[i].d, act, mexp);
            check($sformatf("vec%0d", i), act, tbl[i].exp);
        end

        // Reset asserted during WRITE: pulse already showing is cut to one
        // cycle and the next byte is an address.
        cycle(1, 1, 8'h00, act, mexp);
        cycle(1, 1, 8'h06, act, mexp);
        cycle(1, 1, 8'h00, act, mexp);
        cycle(0, 1, 8'h00, act, mexp);
        check("rst_in_write_pulse", act, {1'b0, 16'h0006, 1'b0, 1'b0});
        cycle(1, 0, 8'h00, act, mexp);
        check("rst_in_write_after", act, {1'b1, 16'h0000, 1'b0, 1'b0});
        cycle(1, 1, 8'h00, act, mexp);
        cycle(1, 1, 8'h07, act, mexp);
        cycle(1, 1, 8'h00, act, mexp);
        cycle(1, 0, 8'h00, act, mexp);
        check("rst_in_write_next", act, {1'b0, 16'h0007, 1'b0, 1'b0});

        // Randomized traffic against the model
        pv = 90;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            bit         v;
            bit         rn;
            if (i % 150 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pv = 95;
                    1:       pv = 60;
                    default: pv = 15;
                endcase
            end
            v  = ($urandom_range(0, 99) < pv);
            rn = ($urandom_range(0, 249) != 0);
            d  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            cycle(rn, v, d, act, mexp);
            check($sformatf("rand%0d", i), act, mexp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
